// File: rtl/alu_serial_ctrl_pkg.sv
// Shared definitions for the bit-serial ALU controller: opcodes, FSM states
// and the opcode legality check.
package alu_ctrl_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT);
    endfunction

endpackage

// File: rtl/alu_serial_ctrl_if.sv
// Request/response bundle between the control unit and the serial ALU
// controller. The master issues operations; the slave (controller) answers.
interface alu_serial_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             err;

    modport master (
        output start, op, a, b, cin,
        input  busy, done, result, cout, err
    );

    modport slave (
        input  start, op, a, b, cin,
        output busy, done, result, cout, err
    );
endinterface

// File: rtl/alu_serial_ctrl_slice.sv
// One-bit ALU slice: AND, OR, or full add of a with (b ^ add_sub).
module alu_slice (
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       add_sub,
    input  logic [1:0] op,
    output logic       r,
    output logic       co
);
    logic b_eff;
    logic sum;

    // Select the slice function; the adder output serves ADD, SUB and SLT.
    always_comb begin
        b_eff = b ^ add_sub;
        sum   = a ^ b_eff ^ cin;
        co    = (a & b_eff) | (cin & (a ^ b_eff));
        case (op)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            default: r = sum;
        endcase
    end
endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer: feeds one ALU slice LSB-first, one bit per clock,
// holding the carry between bits and assembling the result in a shifter.
module alu_serial_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_ctrl_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   sr_q, sr_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;

    logic               slice_r;
    logic               slice_co;

    alu_slice u_slice (
        .a       (a_q[0]),
        .b       (b_q[0]),
        .cin     (carry_q),
        .add_sub (op_q[2]),
        .op      (op_q[1:0]),
        .r       (slice_r),
        .co      (slice_co)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        result_d = result_q;
        cout_d   = cout_q;
        err_d    = err_q;
        done_d   = 1'b0;
        busy_d   = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    busy_d = 1'b1;
                    if (op_legal(bus.op)) begin
                        a_d     = bus.a;
                        b_d     = bus.b;
                        op_d    = bus.op;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = RUN;
                        if (bus.op == OP_ADD || bus.op == OP_SUB)
                            carry_d = bus.cin;
                        else if (bus.op == OP_SLT)
                            carry_d = 1'b1;
                        else
                            carry_d = 1'b0;
                    end else begin
                        err_d    = 1'b1;
                        result_d = '0;
                        cout_d   = 1'b0;
                        done_d   = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            RUN: begin
                a_d  = a_q >> 1;
                b_d  = b_q >> 1;
                sr_d = (sr_q >> 1) | (WIDTH'(slice_r) << (WIDTH - 1));
                // Every legal op with op[1] set uses the adder chain.
                if (op_q[1])
                    carry_d = slice_co;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    if (op_q == OP_SLT) begin
                        // Unsigned a < b exactly when a + ~b + 1 does not carry out.
                        result_d    = '0;
                        result_d[0] = ~slice_co;
                    end else begin
                        result_d = sr_d;
                    end
                    cout_d = (op_q == OP_ADD || op_q == OP_SUB) ? slice_co : 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sr_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl: the driver pushes hand-computed
// expectations, the monitor pops and compares on every done pulse.
module tb_alu_serial_ctrl;
    import alu_ctrl_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         err;
        int unsigned  due;
        string        name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_ctrl_if #(.WIDTH(W)) bus ();

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual_result=%0h expected=no_done", bus.result);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, 32'(bus.result), 32'(e.res));
                chk({e.name, "_cout"},   32'(bus.cout),   32'(e.cout));
                chk({e.name, "_err"},    32'(bus.err),    32'(e.err));
                chk({e.name, "_latency"}, cyc, e.due);
            end
        end
    end

    task automatic issue(input string name, input logic [2:0] o, input logic [W-1:0] aa,
                         input logic [W-1:0] bb, input logic c, input logic [W-1:0] er,
                         input logic ec, input logic ee);
        exp_t e;
        @(negedge clk);
        bus.op    = o;
        bus.a     = aa;
        bus.b     = bb;
        bus.cin   = c;
        bus.start = 1'b1;
        e.res  = er;
        e.cout = ec;
        e.err  = ee;
        e.due  = cyc + (ee ? 1 : W + 1);
        e.name = name;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble operands after acceptance; they must not matter.
        bus.a   = ~aa;
        bus.b   = ~bb;
        bus.cin = ~c;
        bus.op  = OP_OR;
    endtask

    task automatic wait_done(input string name);
        bit busy_bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (sb.size() == 0) break;
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            @(negedge clk);
        end
        chk({name, "_busy"}, 32'(busy_bad), 32'd0);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=no_done expected=done", name);
            sb.delete();
        end
    endtask

    task automatic run(input string name, input logic [2:0] o, input logic [W-1:0] aa,
                       input logic [W-1:0] bb, input logic c, input logic [W-1:0] er,
                       input logic ec, input logic ee);
        issue(name, o, aa, bb, c, er, ec, ee);
        wait_done(name);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = OP_AND;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        #12;
        chk("reset_busy",   32'(bus.busy),   32'd0);
        chk("reset_done",   32'(bus.done),   32'd0);
        chk("reset_result", 32'(bus.result), 32'd0);
        chk("reset_cout",   32'(bus.cout),   32'd0);
        chk("reset_err",    32'(bus.err),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run("add_ff_01",   OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run("sub_05_07",   OP_SUB, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run("sub_07_05",   OP_SUB, 8'h07, 8'h05, 1'b1, 8'h02, 1'b1, 1'b0);
        run("sub_borrow",  OP_SUB, 8'h07, 8'h05, 1'b0, 8'h01, 1'b1, 1'b0);
        run("slt_3_200",   OP_SLT, 8'd3,   8'd200, 1'b0, 8'h01, 1'b0, 1'b0);
        run("slt_200_3",   OP_SLT, 8'd200, 8'd3,   1'b1, 8'h00, 1'b0, 1'b0);
        run("slt_eq",      OP_SLT, 8'h5A, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0);
        run("and_a5_3c",   OP_AND, 8'hA5, 8'h3C, 1'b1, 8'h24, 1'b0, 1'b0);
        run("or_a5_3c",    OP_OR,  8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0, 1'b0);
        run("illegal_100", 3'b100, 8'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b1);
        run("add_after_err", OP_ADD, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        run("illegal_011", 3'b011, 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1);

        // Stray start while busy must be ignored.
        issue("add_midstart", OP_ADD, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_OR;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("add_midstart");

        // Leave a nonzero result, then reset in the middle of a run.
        run("or_pre_reset", OP_OR, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0);
        issue("sub_aborted", OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midreset_busy",   32'(bus.busy),   32'd0);
        chk("midreset_done",   32'(bus.done),   32'd0);
        chk("midreset_result", 32'(bus.result), 32'd0);
        chk("midreset_cout",   32'(bus.cout),   32'd0);
        chk("midreset_err",    32'(bus.err),    32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("sub_after_reset", OP_SUB, 8'h10, 8'h01, 1'b1, 8'h0F, 1'b1, 1'b0);

        repeat (20) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
